// File: rtl/rst_seq_pkg.sv
// Shared types and widths for the reset sequencer.
package rst_seq_pkg;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned LOSS_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StCount    = 2'd1,
    StDone     = 2'd2,
    StAbort    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous bit, async active-low reset to 0.
module sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rst_seq.sv
// Sequenced reset release gated by PLL lock; aborts on lock loss or software request.
// Optional lock-stability filter enabled by defining RST_SEQ_LOCK_FILTER_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_STAGES   = 3,
  parameter int unsigned STAGE_DLY  = 1024,
  parameter int unsigned FILTER_LEN = 16
) (
  input  logic                clk_408MHz,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                sw_rst_req,
  output logic [N_STAGES-1:0] stage_rst_n,
  output logic                seq_done,
  output logic [1:0]          seq_state,
  output logic [LOSS_W-1:0]   lock_loss_cnt
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STAGES - 1);

  if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_stages
    $error("rst_seq: N_STAGES out of range");
  end
  if (STAGE_DLY < 2 || STAGE_DLY > (1 << CNT_W)) begin : g_bad_dly
    $error("rst_seq: STAGE_DLY out of range");
  end
  if (FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_bad_filter
    $error("rst_seq: FILTER_LEN out of range");
  end

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_STAGES-1:0] stage_q, stage_d, stage_shl;
  logic                done_q, done_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic                lock_s;
  logic                lock_ok;
  logic                release_stage;

  sync_bit u_lock_sync (
    .clk   (clk_408MHz),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

`ifdef RST_SEQ_LOCK_FILTER_EN
  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  logic [7:0] filt_q, filt_d;

  // Counts consecutive high lock_s samples while waiting; any low sample restarts it.
  always_comb begin
    filt_d = '0;
    if (state_q == StWaitLock && lock_s && !lock_ok) begin
      filt_d = filt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_408MHz or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end

  assign lock_ok = lock_s && (filt_q == FILT_LAST);
`else
  assign lock_ok = lock_s;
`endif

  always_ff @(posedge clk_408MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitLock;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    loss_d  = loss_q;
    unique case (state_q)
      StWaitLock: begin
        if (lock_ok) begin
          state_d = StCount;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StCount, StDone: begin
        if (!lock_s || sw_rst_req) begin
          state_d = StAbort;
          cnt_d   = '0;
          idx_d   = '0;
          // Lock loss counts once even when a software request coincides.
          if (!lock_s && loss_q != LOSS_MAX) begin
            loss_d = loss_q + 1'b1;
          end
        end else if (state_q == StCount) begin
          if (cnt_q == DLY_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = StDone;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StAbort: begin
        state_d = StWaitLock;
        cnt_d   = '0;
        idx_d   = '0;
      end
      default: state_d = StWaitLock;
    endcase
  end

  // Shifting a one in from bit 0 keeps the outputs thermometer-coded by construction.
  always_comb begin
    stage_shl[0] = 1'b1;
    for (int k = 1; k < int'(N_STAGES); k++) begin
      stage_shl[k] = stage_q[k-1];
    end
  end

  assign release_stage = (state_q == StCount) && (state_d != StAbort) && (cnt_q == DLY_LAST);

  always_comb begin
    stage_d = stage_q;
    done_d  = (state_d == StDone);
    if (state_d == StAbort || state_d == StWaitLock) begin
      stage_d = '0;
    end else if (release_stage) begin
      stage_d = stage_shl;
    end
  end

  always_ff @(posedge clk_408MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      loss_q  <= loss_d;
    end
  end

  assign stage_rst_n   = stage_q;
  assign seq_done      = done_q;
  assign seq_state     = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq (N_STAGES=3, STAGE_DLY=8, FILTER_LEN=16): vector table plus corner sequences.
module tb_rst_seq;

  localparam int FILT   = 16;
`ifdef RST_SEQ_LOCK_FILTER_EN
  localparam int WAIT_X = FILT - 1;
`else
  localparam int WAIT_X = 0;
`endif

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  logic       clk_408MHz;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_rst_req;
  logic [2:0] stage_rst_n;
  logic       seq_done;
  logic [1:0] seq_state;
  logic [7:0] lock_loss_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       lock;
    logic       sw;
    int         n;
    logic [2:0] stage;
    logic       done;
    logic [1:0] state;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  rst_seq #(
    .N_STAGES   (3),
    .STAGE_DLY  (8),
    .FILTER_LEN (FILT)
  ) dut (
    .clk_408MHz    (clk_408MHz),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .stage_rst_n   (stage_rst_n),
    .seq_done      (seq_done),
    .seq_state     (seq_state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial clk_408MHz = 1'b0;
  always #5 clk_408MHz = ~clk_408MHz;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] stage, input logic done,
                           input logic [1:0] state, input logic [7:0] cnt);
    check({tag, " stage"}, {5'd0, stage_rst_n}, {5'd0, stage});
    check({tag, " done"},  {7'd0, seq_done},    {7'd0, done});
    check({tag, " state"}, {6'd0, seq_state},   {6'd0, state});
    check({tag, " cnt"},   lock_loss_cnt,       cnt);
  endtask

  task automatic add(input logic lock, input logic sw, input int n, input logic [2:0] stage,
                     input logic done, input logic [1:0] state, input logic [7:0] cnt);
    vec_t v;
    v.lock = lock; v.sw = sw; v.n = n; v.stage = stage;
    v.done = done; v.state = state; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk_408MHz);
    #1;
  endtask

  // Thermometer invariant: no released bit above an unreleased one.
  always @(negedge clk_408MHz) begin
    if (rst_n) begin
      check("thermometer", {5'd0, stage_rst_n & (stage_rst_n + 3'd1)}, 8'd0);
    end
  end

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;

    // lock, sw, edges, stage, done, state, lock_loss_cnt
    add(1, 0, 2 + WAIT_X, 3'b000, 0, S_WAIT,  0);
    add(1, 0, 1,          3'b000, 0, S_COUNT, 0);
    add(1, 0, 7,          3'b000, 0, S_COUNT, 0);
    add(1, 0, 1,          3'b001, 0, S_COUNT, 0);
    add(1, 0, 7,          3'b001, 0, S_COUNT, 0);
    add(1, 0, 1,          3'b011, 0, S_COUNT, 0);
    add(1, 0, 7,          3'b011, 0, S_COUNT, 0);
    add(1, 0, 1,          3'b111, 1, S_DONE,  0);
    add(1, 0, 5,          3'b111, 1, S_DONE,  0);
    add(1, 1, 1,          3'b000, 0, S_ABORT, 0);
    add(1, 0, 1,          3'b000, 0, S_WAIT,  0);
    add(1, 0, 1 + WAIT_X, 3'b000, 0, S_COUNT, 0);
    add(1, 0, 8,          3'b001, 0, S_COUNT, 0);
    add(1, 0, 4,          3'b001, 0, S_COUNT, 0);
    add(0, 0, 2,          3'b001, 0, S_COUNT, 0);
    add(0, 0, 1,          3'b000, 0, S_ABORT, 1);
    add(0, 1, 1,          3'b000, 0, S_WAIT,  1);
    add(0, 1, 3,          3'b000, 0, S_WAIT,  1);
    add(1, 1, 2 + WAIT_X, 3'b000, 0, S_WAIT,  1);
    add(1, 1, 1,          3'b000, 0, S_COUNT, 1);
    add(1, 0, 8,          3'b001, 0, S_COUNT, 1);
    add(1, 0, 8,          3'b011, 0, S_COUNT, 1);
    add(1, 0, 7,          3'b011, 0, S_COUNT, 1);
    add(1, 0, 1,          3'b111, 1, S_DONE,  1);
    add(0, 0, 2,          3'b111, 1, S_DONE,  1);
    add(0, 1, 1,          3'b000, 0, S_ABORT, 2);
    add(0, 0, 1,          3'b000, 0, S_WAIT,  2);

    #12;
    check_all("reset", 3'b000, 0, S_WAIT, 0);

    @(posedge clk_408MHz);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      pll_locked = vecs[i].lock;
      sw_rst_req = vecs[i].sw;
      edges(vecs[i].n);
      check_all($sformatf("row%0d", i), vecs[i].stage, vecs[i].done, vecs[i].state, vecs[i].cnt);
    end
    sw_rst_req = 1'b0;

    // Async reset mid-COUNT: outputs clear with no clock edge.
    pll_locked = 1'b1;
    edges(3 + WAIT_X);
    check("arst entry state", {6'd0, seq_state}, {6'd0, S_COUNT});
    edges(10);
    check_all("arst pre", 3'b001, 0, S_COUNT, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("arst async", 3'b000, 0, S_WAIT, 0);
    edges(3);
    check_all("arst held", 3'b000, 0, S_WAIT, 0);

    // Lock-loss counter saturation over 300 aborts.
    pll_locked = 1'b0;
    #5;
    rst_n = 1'b1;
    edges(1);
    for (int i = 1; i <= 300; i++) begin
      pll_locked = 1'b1;
      edges(3 + WAIT_X);
      pll_locked = 1'b0;
      edges(4);
      if (i == 1)   check("sat 1",   lock_loss_cnt, 8'd1);
      if (i == 254) check("sat 254", lock_loss_cnt, 8'd254);
      if (i == 255) check("sat 255", lock_loss_cnt, 8'd255);
    end
    check_all("sat 300", 3'b000, 0, S_WAIT, 8'd255);

    // Short lock glitch: filtered build stays waiting, unfiltered build starts counting.
    pll_locked = 1'b1;
    edges(5);
    pll_locked = 1'b0;
`ifdef RST_SEQ_LOCK_FILTER_EN
    check("glitch state", {6'd0, seq_state}, {6'd0, S_WAIT});
`else
    check("glitch state", {6'd0, seq_state}, {6'd0, S_COUNT});
`endif
    edges(6);
    check_all("glitch after", 3'b000, 0, S_WAIT, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter N_STAGES, default 3, number of sequenced reset outputs (legal 1..8).
REQ-002 Parameter STAGE_DLY, default 1024, clk_408MHz cycles between successive stage releases (legal 2..2^20).
REQ-003 Parameter FILTER_LEN, default 16, lock-stable cycles required when RST_SEQ_LOCK_FILTER_EN is defined (legal 2..255).
REQ-004 clk_408MHz  input  1  block clock.
REQ-005 rst_n  input  1  asynchronous active-low reset, driven by the 408 MHz synchronized system reset.
REQ-006 pll_locked  input  1  PLL lock indication, asynchronous to clk_408MHz.
REQ-007 sw_rst_req  input  1  single-cycle software reset request, synchronous to clk_408MHz.
REQ-008 stage_rst_n  output  N_STAGES  sequenced active-low resets; bit 0 released first.
REQ-009 seq_done  output  1  high when all stages are released.
REQ-010 seq_state  output  2  current FSM state encoding.
REQ-011 lock_loss_cnt  output  8  saturating count of lock-loss aborts.

Function
REQ-012 pll_locked SHALL pass through a 2-flop synchronizer (lock_s); 2-cycle latency.
REQ-013 FSM states SHALL be WAIT_LOCK=0, COUNT=1, DONE=2, ABORT=3.
REQ-014 WAIT_LOCK: on lock_s=1 go to COUNT with delay counter=0 and stage index=0; sw_rst_req ignored.
REQ-015 COUNT: counter increments each cycle; at counter==STAGE_DLY-1, stage_rst_n[index] SHALL go 1 on the next edge, counter clears, index increments.
REQ-016 Stage k SHALL release exactly (k+1)*STAGE_DLY cycles after the COUNT entry edge; after the last stage, go to DONE with seq_done=1 on the same edge.
REQ-017 stage_rst_n SHALL always be thermometer-coded: bit k high implies all lower bits high.
REQ-018 In COUNT or DONE, lock_s=0 SHALL go to ABORT and increment lock_loss_cnt, saturating at 255.
REQ-019 In COUNT or DONE, sw_rst_req=1 SHALL go to ABORT without incrementing lock_loss_cnt.
REQ-020 Simultaneous lock loss and sw_rst_req SHALL go to ABORT and increment lock_loss_cnt once.
REQ-021 ABORT: all stage_rst_n=0, seq_done=0, counter and index cleared; lasts exactly one cycle, then WAIT_LOCK.
REQ-022 All outputs SHALL be registered; total latency from pll_locked fall to stage_rst_n low SHALL be 3 cycles.

Reset
REQ-023 rst_n low SHALL asynchronously force stage_rst_n=0, seq_done=0, seq_state=WAIT_LOCK, lock_loss_cnt=0, counter=0, index=0, synchronizer flops=0.
REQ-024 rst_n deassertion SHALL take effect on the next clk_408MHz edge; no input is sampled while rst_n is low.

Configuration
REQ-025 With RST_SEQ_LOCK_FILTER_EN defined, WAIT_LOCK SHALL leave only after lock_s is high for FILTER_LEN consecutive cycles; any low sample restarts the filter count.
REQ-026 Without RST_SEQ_LOCK_FILTER_EN, WAIT_LOCK SHALL leave on the first lock_s=1 cycle, and no filter logic SHALL be synthesized.

Structure
REQ-027 Package rst_seq_pkg SHALL hold the FSM state typedef, state encodings, counter width (20) and lock_loss_cnt width (8).
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module, sync_bit, with async active-low reset to 0.

Verification (N_STAGES=3, STAGE_DLY=8, FILTER_LEN=16)
REQ-029 Release rst_n, pll_locked=1 -> stage_rst_n 001/011/111 at 8/16/24 cycles after COUNT entry; seq_done=1 at cycle 24.
REQ-030 pll_locked falls at COUNT cycle 12 -> stage_rst_n=000 three cycles later; lock_loss_cnt=1; relock restarts the full 8/16/24 sequence.
REQ-031 sw_rst_req pulse in DONE -> one ABORT cycle, stage_rst_n=000, lock_loss_cnt unchanged; sequence repeats.
REQ-032 rst_n asserted at COUNT cycle 10 -> all outputs 0 immediately, without a clock edge; lock_loss_cnt=0.
REQ-033 300 lock-loss aborts -> lock_loss_cnt holds 255.
REQ-034 Macro defined, 5-cycle pulse on pll_locked -> FSM stays in WAIT_LOCK; macro undefined -> FSM enters COUNT.
